// File: rtl/disp_timing_gen_prog.sv
// Runtime-programmable display timing generator; timing is shadowed and applied at frame boundaries.
// Latency: outputs are registered together with the state they decode, so they reflect the state entered on the same edge.
// Backpressure: none, free-running while i_en is high. DISP_TG_CFG_CHECK_EN rejects updates with zero pulse/resolution fields.
module disp_timing_gen_prog #(
    parameter int CNT_WIDTH  = 12,
    parameter int DEF_HPULSE = 1,
    parameter int DEF_HBP    = 4,
    parameter int DEF_HRES   = 320,
    parameter int DEF_HFP    = 5,
    parameter int DEF_VPULSE = 1,
    parameter int DEF_VBP    = 3,
    parameter int DEF_VRES   = 240,
    parameter int DEF_VFP    = 5
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [CNT_WIDTH-1:0] i_hpulse,
    input  logic [CNT_WIDTH-1:0] i_hbp,
    input  logic [CNT_WIDTH-1:0] i_hres,
    input  logic [CNT_WIDTH-1:0] i_hfp,
    input  logic [CNT_WIDTH-1:0] i_vpulse,
    input  logic [CNT_WIDTH-1:0] i_vbp,
    input  logic [CNT_WIDTH-1:0] i_vres,
    input  logic [CNT_WIDTH-1:0] i_vfp,
    input  logic                 i_cfg_update,
    output logic                 o_vsync,
    output logic                 o_hsync,
    output logic                 o_de,
    output logic [CNT_WIDTH-1:0] o_hcnt,
    output logic [CNT_WIDTH-1:0] o_vcnt,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic [2:0]           o_Hstate,
    output logic [2:0]           o_Vstate,
    output logic                 o_cfg_err
);
    typedef enum logic [2:0] {IDLE = 3'd0, SYNC = 3'd1, BP = 3'd2, ACT = 3'd3, FP = 3'd4} state_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef struct packed {
        cnt_t hpulse, hbp, hres, hfp, vpulse, vbp, vres, vfp;
    } timing_t;

    localparam cnt_t ONE = cnt_t'(1);
    localparam timing_t DEF_CFG = '{cnt_t'(DEF_HPULSE), cnt_t'(DEF_HBP), cnt_t'(DEF_HRES), cnt_t'(DEF_HFP),
                                    cnt_t'(DEF_VPULSE), cnt_t'(DEF_VBP), cnt_t'(DEF_VRES), cnt_t'(DEF_VFP)};

    function automatic cnt_t nz(input cnt_t v);
        return (v == '0) ? ONE : v;
    endfunction

    // Pulse and resolution must be at least one unit long for the state sequence to advance.
    function automatic timing_t clamp_cfg(input timing_t t);
        timing_t r;
        r        = t;
        r.hpulse = nz(t.hpulse);
        r.hres   = nz(t.hres);
        r.vpulse = nz(t.vpulse);
        r.vres   = nz(t.vres);
        return r;
    endfunction

    timing_t act, pend, req;
    logic    pend_vld;
    state_t  h_state, v_state, h_nxt, v_nxt;
    cnt_t    h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt, h_len, v_len;
    logic    h_last, v_last, line_end, frame_end, transfer, upd_bad, upd_ok, de_nxt;

    assign req = '{i_hpulse, i_hbp, i_hres, i_hfp, i_vpulse, i_vbp, i_vres, i_vfp};

`ifdef DISP_TG_CFG_CHECK_EN
    assign upd_bad = i_cfg_update && (i_hpulse == '0 || i_hres == '0 || i_vpulse == '0 || i_vres == '0);
`else
    assign upd_bad = 1'b0;
`endif
    assign upd_ok = i_cfg_update && !upd_bad;

    always_comb begin
        h_len = '0;
        v_len = '0;
        case (h_state)
            SYNC:    h_len = act.hpulse;
            BP:      h_len = act.hbp;
            ACT:     h_len = act.hres;
            FP:      h_len = act.hfp;
            default: h_len = '0;
        endcase
        case (v_state)
            SYNC:    v_len = act.vpulse;
            BP:      v_len = act.vbp;
            ACT:     v_len = act.vres;
            FP:      v_len = act.vfp;
            default: v_len = '0;
        endcase
    end

    // Counters compare against length-1 so no line or frame total is ever formed.
    assign h_last    = (h_cnt == h_len - ONE);
    assign v_last    = (v_cnt == v_len - ONE);
    assign line_end  = h_last && (h_state == FP || (h_state == ACT && act.hfp == '0));
    assign frame_end = line_end && v_last && (v_state == FP || (v_state == ACT && act.vfp == '0));
    assign transfer  = i_en && pend_vld && (h_state == IDLE || frame_end);

    always_comb begin
        h_nxt = h_state;
        v_nxt = v_state;
        if (!i_en) begin
            h_nxt = IDLE;
            v_nxt = IDLE;
        end else begin
            case (h_state)
                IDLE:    h_nxt = SYNC;
                SYNC:    if (h_last) h_nxt = (act.hbp != '0) ? BP : ACT;
                BP:      if (h_last) h_nxt = ACT;
                ACT:     if (h_last) h_nxt = (act.hfp != '0) ? FP : SYNC;
                FP:      if (h_last) h_nxt = SYNC;
                default: h_nxt = IDLE;
            endcase
            case (v_state)
                IDLE:    v_nxt = SYNC;
                SYNC:    if (line_end && v_last) v_nxt = (act.vbp != '0) ? BP : ACT;
                BP:      if (line_end && v_last) v_nxt = ACT;
                ACT:     if (line_end && v_last) v_nxt = (act.vfp != '0) ? FP : SYNC;
                FP:      if (line_end && v_last) v_nxt = SYNC;
                default: v_nxt = IDLE;
            endcase
        end
        h_cnt_nxt = (h_nxt != h_state || h_nxt == IDLE) ? '0 : h_cnt + ONE;
        v_cnt_nxt = (v_nxt != v_state || v_nxt == IDLE) ? '0 : (line_end ? v_cnt + ONE : v_cnt);
        de_nxt    = (h_nxt == ACT) && (v_nxt == ACT);
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state  <= IDLE;
            v_state  <= IDLE;
            h_cnt    <= '0;
            v_cnt    <= '0;
            act      <= DEF_CFG;
            pend     <= DEF_CFG;
            pend_vld <= 1'b0;
            o_hsync  <= 1'b0;
            o_vsync  <= 1'b0;
            o_de     <= 1'b0;
            o_hcnt   <= '0;
            o_vcnt   <= '0;
            o_sof    <= 1'b0;
            o_eof    <= 1'b0;
            o_Hstate <= IDLE;
            o_Vstate <= IDLE;
        end else begin
            h_state  <= h_nxt;
            v_state  <= v_nxt;
            h_cnt    <= h_cnt_nxt;
            v_cnt    <= v_cnt_nxt;
            o_hsync  <= (h_nxt == SYNC);
            o_vsync  <= (v_nxt == SYNC);
            o_de     <= de_nxt;
            o_hcnt   <= de_nxt ? h_cnt_nxt : '0;
            o_vcnt   <= de_nxt ? v_cnt_nxt : '0;
            o_sof    <= de_nxt && h_cnt_nxt == '0 && v_cnt_nxt == '0;
            o_eof    <= de_nxt && h_cnt_nxt == act.hres - ONE && v_cnt_nxt == act.vres - ONE;
            o_Hstate <= h_nxt;
            o_Vstate <= v_nxt;
            if (transfer) begin
                act      <= clamp_cfg(pend);
                pend_vld <= 1'b0;
            end
            // A capture in the transfer cycle lands in pending for the following boundary.
            if (upd_ok) begin
                pend     <= req;
                pend_vld <= 1'b1;
            end
        end
    end

`ifdef DISP_TG_CFG_CHECK_EN
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n)       o_cfg_err <= 1'b0;
        else if (upd_bad) o_cfg_err <= 1'b1;
        else if (upd_ok)  o_cfg_err <= 1'b0;
    end
`else
    assign o_cfg_err = 1'b0;
`endif
endmodule

// File: tb/tb_disp_timing_gen_prog.sv
// Bench for disp_timing_gen_prog: per-cycle comparison against a position-based reference model,
// plus directed tables and sequences for small-mode, enable, config-check, reset and default-frame behaviour.
module tb_disp_timing_gen_prog;
    localparam int W = 12;
    localparam int DEFV[8] = '{1, 4, 320, 5, 1, 3, 240, 5};

    logic         clk = 1'b0;
    logic         rst_n, en, upd;
    logic [W-1:0] cfg_in [8];
    logic         vs, hs, de, sof, eof, err;
    logic [W-1:0] hc, vc;
    logic [2:0]   hst, vst;

    always #5 clk = ~clk;

    disp_timing_gen_prog dut (
        .i_clk(clk), .rst_n(rst_n), .i_en(en),
        .i_hpulse(cfg_in[0]), .i_hbp(cfg_in[1]), .i_hres(cfg_in[2]), .i_hfp(cfg_in[3]),
        .i_vpulse(cfg_in[4]), .i_vbp(cfg_in[5]), .i_vres(cfg_in[6]), .i_vfp(cfg_in[7]),
        .i_cfg_update(upd),
        .o_vsync(vs), .o_hsync(hs), .o_de(de), .o_hcnt(hc), .o_vcnt(vc),
        .o_sof(sof), .o_eof(eof), .o_Hstate(hst), .o_Vstate(vst), .o_cfg_err(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: timing sets plus the (x, y) position inside the frame.
    int a [8];
    int p [8];
    bit pflag, merr, mrun;
    int mx, my;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            a[i] = DEFV[i];
            p[i] = DEFV[i];
        end
        pflag = 0; merr = 0; mrun = 0; mx = 0; my = 0;
    endtask

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step();
        bit boundary;
        int line_len, frame_len;
        boundary  = 0;
        line_len  = a[0] + a[1] + a[2] + a[3];
        frame_len = a[4] + a[5] + a[6] + a[7];
        if (!en) begin
            mrun = 0; mx = 0; my = 0;
        end else if (!mrun) begin
            mrun = 1; mx = 0; my = 0; boundary = 1;
        end else begin
            mx++;
            if (mx == line_len) begin
                mx = 0;
                my++;
                if (my == frame_len) begin
                    my = 0;
                    boundary = 1;
                end
            end
        end
        if (boundary && pflag) begin
            for (int i = 0; i < 8; i++) a[i] = p[i];
            a[0] = nz(a[0]); a[2] = nz(a[2]); a[4] = nz(a[4]); a[6] = nz(a[6]);
            pflag = 0;
        end
        if (upd) begin
`ifdef DISP_TG_CFG_CHECK_EN
            if (cfg_in[0] == 0 || cfg_in[2] == 0 || cfg_in[4] == 0 || cfg_in[6] == 0) begin
                merr = 1;
            end else begin
                for (int i = 0; i < 8; i++) p[i] = int'(cfg_in[i]);
                pflag = 1;
                merr  = 0;
            end
`else
            for (int i = 0; i < 8; i++) p[i] = int'(cfg_in[i]);
            pflag = 1;
`endif
        end
    endtask

    function automatic int seg(input int pos, input int pw, input int bp, input int res);
        if (pos < pw)            return 1;
        if (pos < pw + bp)       return 2;
        if (pos < pw + bp + res) return 3;
        return 4;
    endfunction

    function automatic logic [35:0] exp_vec();
        int hs_st, vs_st, xh, yv;
        bit d, so, eo;
        hs_st = 0; vs_st = 0; xh = 0; yv = 0; so = 0; eo = 0;
        if (mrun) begin
            hs_st = seg(mx, a[0], a[1], a[2]);
            vs_st = seg(my, a[4], a[5], a[6]);
        end
        d = (hs_st == 3) && (vs_st == 3);
        if (d) begin
            xh = mx - a[0] - a[1];
            yv = my - a[4] - a[5];
            so = (xh == 0) && (yv == 0);
            eo = (xh == a[2] - 1) && (yv == a[6] - 1);
        end
        return {hs_st == 1, vs_st == 1, d, so, eo, merr, 3'(hs_st), 3'(vs_st), 12'(xh), 12'(yv)};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {hs, vs, de, sof, eof, err, hst, vst, hc, vc};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic set_in(input int h0, input int h1, input int h2, input int h3,
                          input int v0, input int v1, input int v2, input int v3);
        cfg_in[0] = W'(h0); cfg_in[1] = W'(h1); cfg_in[2] = W'(h2); cfg_in[3] = W'(h3);
        cfg_in[4] = W'(v0); cfg_in[5] = W'(v1); cfg_in[6] = W'(v2); cfg_in[7] = W'(v3);
    endtask

    task automatic prog(input int h0, input int h1, input int h2, input int h3,
                        input int v0, input int v1, input int v2, input int v3);
        set_in(h0, h1, h2, h3, v0, v1, v2, v3);
        upd = 1'b1;
        cycle();
        upd = 1'b0;
    endtask

    typedef struct {
        int t;
        bit hs, vs, de, sof, eof;
        int hc, vc;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, de_n, hs_n, vs_n, sof_n, eof_n, hs2, exp_de;

        // Small mode (1,0,4,1 / 1,0,2,1): 6-clock lines, 4 lines per frame, t counted from the first SYNC cycle.
        tbl[0]  = '{0,  1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{5,  0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{6,  1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{7,  0, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{10, 0, 0, 1, 0, 0, 3, 0};
        tbl[5]  = '{11, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{13, 0, 0, 1, 0, 0, 0, 1};
        tbl[7]  = '{16, 0, 0, 1, 0, 1, 3, 1};
        tbl[8]  = '{18, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{24, 1, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{31, 0, 0, 1, 1, 0, 0, 0};

        en = 1'b0; upd = 1'b0; rst_n = 1'b0;
        set_in(1, 4, 320, 5, 1, 3, 240, 5);
        model_reset();
        #7;
        check("reset_state", 64'(dut_vec()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        prog(1, 0, 4, 1, 1, 0, 2, 1);
        en = 1'b1;
        for (int t = 0; t < 32; t++) begin
            cycle();
            for (int k = 0; k < 11; k++) begin
                if (tbl[k].t == t)
                    check("small_tbl", 64'({hs, vs, de, sof, eof, hc, vc}),
                          64'({tbl[k].hs, tbl[k].vs, tbl[k].de, tbl[k].sof, tbl[k].eof,
                               12'(tbl[k].hc), 12'(tbl[k].vc)}));
            end
        end

        // Drop enable while vertically active, then restart.
        n = 0;
        while (vst != 3'd3 && n < 64) begin
            cycle();
            n++;
        end
        check("reach_vact", 64'(vst), 64'd3);
        en = 1'b0;
        cycle();
        check("en_drop", 64'(dut_vec()), 64'd0);
        en = 1'b1;
        cycle();
        check("restart_sync", 64'({hs, vs, hst, vst}), 64'({1'b1, 1'b1, 3'd1, 3'd1}));

        // Zero hres: rejected with the check enabled, otherwise a 1-clock active line.
        prog(1, 0, 0, 1, 1, 0, 2, 1);
`ifdef DISP_TG_CFG_CHECK_EN
        check("cfg_err_set", 64'(err), 64'd1);
        exp_de = 8;
`else
        exp_de = 4;
`endif
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(hst == 3'd1 && vst == 3'd1) && n < 64);
        check("wrap_seen", 64'(hst == 3'd1 && vst == 3'd1), 64'd1);
        de_n = 0;
        for (int i = 0; i < 24; i++) begin
            de_n += int'(de);
            cycle();
        end
        check("zero_hres_de", 64'(de_n), 64'(exp_de));
        prog(1, 0, 4, 1, 1, 0, 2, 1);
        check("cfg_err_clear", 64'(err), 64'd0);

        // Randomized small modes, updates and enable toggles against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) begin
                set_in(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                upd = 1'b1;
            end
            cycle();
            upd = 1'b0;
        end
        en = 1'b1;

        // Asynchronous reset in the middle of an active line of a programmed mode.
        prog(1, 2, 6, 1, 1, 1, 3, 1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(de == 1'b1 && hc == 12'd2) && n < 300);
        check("reach_mid_line", 64'(de == 1'b1 && hc == 12'd2), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 64'(dut_vec()), 64'd0);
        model_reset();
        set_in(1, 4, 320, 5, 1, 3, 240, 5);
        @(negedge clk);
        rst_n = 1'b1;

        // Full default frame, with two mid-frame hres updates; only the second applies next frame.
        hs_n = 0; vs_n = 0; de_n = 0; sof_n = 0; eof_n = 0; hs2 = 0;
        for (int t = 0; t < 82170 + 510; t++) begin
            if (t == 40000) begin cfg_in[2] = W'(200); upd = 1'b1; end
            if (t == 50000) begin cfg_in[2] = W'(160); upd = 1'b1; end
            cycle();
            upd = 1'b0;
            if (t < 82170) begin
                hs_n  += int'(hs);
                vs_n  += int'(vs);
                de_n  += int'(de);
                sof_n += int'(sof);
                eof_n += int'(eof);
            end else begin
                hs2 += int'(hs);
            end
            if (t == 1324) check("before_first_de", 64'(de), 64'd0);
            if (t == 1325) check("first_de", 64'({de, sof, hc, vc}), 64'({1'b1, 1'b1, 12'd0, 12'd0}));
            if (t == 82170) check("frame_wrap_sync", 64'({hs, vs}), 64'd3);
            if (t == 82340) check("new_line_len", 64'(hs), 64'd1);
        end
        check("def_hsync_lines", 64'(hs_n), 64'd249);
        check("def_vsync_clks", 64'(vs_n), 64'd330);
        check("def_de_count", 64'(de_n), 64'd76800);
        check("def_sof_count", 64'(sof_n), 64'd1);
        check("def_eof_count", 64'(eof_n), 64'd1);
        check("new_mode_hsyncs", 64'(hs2), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
